// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart transmit FIFO: default sizing and the
// drain controller state encoding.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_ADDR_W       = 4;
    localparam int DEFAULT_DEPTH        = 1 << DEFAULT_ADDR_W;
    localparam int DEFAULT_GUARD_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } tx_state_e;

    // Width of a counter that must be able to hold the value `cycles`.
    function automatic int guard_w(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port, status flags and uart handshake of uart_tx_fifo.
// The master side is the SoC/testbench, the slave side is the FIFO itself.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int addr_w = DEFAULT_ADDR_W
) ();

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [addr_w:0] level;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    tx_data;
    logic          tx_wr;
    logic          tx_busy;
    logic          idle;

    modport master (
        output wr_data,
        output wr_en,
        output ovf_clr,
        output tx_busy,
        input  full,
        input  empty,
        input  level,
        input  overflow,
        input  tx_data,
        input  tx_wr,
        input  idle
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        input  ovf_clr,
        input  tx_busy,
        output full,
        output empty,
        output level,
        output overflow,
        output tx_data,
        output tx_wr,
        output idle
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo_byte.sv
// Byte-wide synchronous FIFO: storage, wrapping pointers, registered
// level/full/empty and a sticky overflow flag.
module sync_fifo_byte
    import uart_tx_fifo_pkg::*;
#(
    parameter int addr_w = DEFAULT_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      wr_data,
    input  logic            wr_en,
    input  logic            pop,
    input  logic            ovf_clr,
    output logic [7:0]      rd_data,
    output logic            full,
    output logic            empty,
    output logic [addr_w:0] level,
    output logic            overflow
);

    localparam int              DEPTH   = 1 << addr_w;
    localparam logic [addr_w:0] DEPTH_L = (addr_w + 1)'(DEPTH);
    localparam logic [addr_w:0] LVL_ONE = (addr_w + 1)'(1);
    localparam logic [addr_w-1:0] PTR_ONE = addr_w'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [addr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_w:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop_ok;

    always_comb begin
        // Fullness is judged on the registered value, so a same-cycle pop
        // never rescues a write attempted while full.
        push     = wr_en && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = push   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Storage has no reset so it can map onto RAM; pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller that hands bytes to the uart one at a
// time over the tx_data/tx_wr/tx_busy handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int addr_w       = DEFAULT_ADDR_W,
    parameter int guard_cycles = DEFAULT_GUARD_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int          GW         = guard_w(guard_cycles);
    localparam logic [GW-1:0] GUARD_ONE = GW'(1);
    localparam logic [GW-1:0] GUARD_END = GW'(guard_cycles);

    tx_state_e       state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic            pop;
    logic [7:0]      fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [addr_w:0] fifo_level;
    logic            fifo_overflow;

    sync_fifo_byte #(
        .addr_w (addr_w)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (bus.wr_data),
        .wr_en    (bus.wr_en),
        .pop      (pop),
        .ovf_clr  (bus.ovf_clr),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (fifo_overflow)
    );

    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rd_data;
                    tx_wr_d   = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                guard_d = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // If the uart never reports busy, assume it took the byte.
                if (bus.tx_busy) begin
                    state_d = S_DRAIN;
                end else begin
                    guard_d = guard_q + GUARD_ONE;
                    if (guard_d == GUARD_END) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            guard_q   <= '0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr    = tx_wr_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = fifo_level;
    assign bus.overflow = fifo_overflow;
    assign bus.idle     = fifo_empty && (state_q == S_IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small uart busy model logs every tx_wr
// pulse, and each scenario compares against hand-computed expectations.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.addr_w(4)) bus();

    uart_tx_fifo #(
        .addr_w       (4),
        .guard_cycles (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // uart model state
    int         busy_len = 4;
    bit         uart_en = 1'b1;
    bit         force_busy = 1'b0;
    int         remain = 0;
    bit         pend = 1'b0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         pulse_cyc[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // uart: busy rises the cycle after a tx_wr pulse and lasts busy_len cycles
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (remain > 0) remain--;
            if (pend) begin
                remain = busy_len;
                pend = 1'b0;
            end
            bus.tx_busy = force_busy || (remain > 0);
            if (bus.tx_wr === 1'b1) begin
                rx_q.push_back(bus.tx_data);
                pulse_cyc.push_back(cyc);
                $display("tx byte=%02h cycle=%0d", bus.tx_data, cyc);
                if (uart_en) pend = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_data = first + 8'(i);
            bus.wr_en = 1'b1;
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.idle !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, bus.idle, 1);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // reset held with writes attempted
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_empty", bus.empty, 1);
            check_val("rst_level", bus.level, 0);
            check_val("rst_tx_wr", bus.tx_wr, 0);
        end
        check_val("rst_full", bus.full, 0);
        check_val("rst_overflow", bus.overflow, 0);
        check_val("rst_tx_data", bus.tx_data, 8'h00);
        tick();
        bus.wr_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_idle", bus.idle, 1);

        // single byte, 100-cycle uart
        rx_q.delete();
        busy_len = 100;
        tick();
        bus.wr_data = 8'hA5;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check_val("lat_c1_level", bus.level, 1);
        check_val("lat_c1_tx_wr", bus.tx_wr, 0);
        tick();
        @(negedge clk);
        check_val("lat_c2_tx_wr", bus.tx_wr, 1);
        check_val("lat_c2_tx_data", bus.tx_data, 8'hA5);
        tick();
        @(negedge clk);
        check_val("lat_c3_tx_wr", bus.tx_wr, 0);
        check_val("lat_c3_idle", bus.idle, 0);
        wait_idle("single_idle", 300);
        check_val("single_pulses", rx_q.size(), 1);
        if (rx_q.size() > 0) check_val("single_byte", rx_q[0], 8'hA5);
        check_val("single_hold_data", bus.tx_data, 8'hA5);

        // burst of 16 while uart busy, then drain in order
        rx_q.delete();
        busy_len = 3;
        tick();
        force_busy = 1'b1;
        tick();
        tick();
        write_seq(8'h00, 16);
        @(negedge clk);
        check_val("burst_full", bus.full, 1);
        check_val("burst_level", bus.level, 16);
        check_val("burst_no_ovf", bus.overflow, 0);
        tick();
        force_busy = 1'b0;
        wait_idle("burst_idle", 600);
        check_val("burst_pulses", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            check_val($sformatf("burst_byte%0d", i), rx_q[i], 32'(i));
        end
        check_val("burst_end_level", bus.level, 0);
        check_val("burst_end_empty", bus.empty, 1);

        // overflow: 17 writes while uart busy
        rx_q.delete();
        tick();
        force_busy = 1'b1;
        tick();
        tick();
        write_seq(8'h40, 17);
        @(negedge clk);
        check_val("ovf_level", bus.level, 16);
        check_val("ovf_full", bus.full, 1);
        check_val("ovf_flag", bus.overflow, 1);
        tick();
        bus.wr_data = 8'hEE;
        bus.wr_en = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check_val("ovf_set_wins", bus.overflow, 1);
        check_val("ovf_level_kept", bus.level, 16);
        tick();
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check_val("ovf_clr", bus.overflow, 0);
        tick();
        force_busy = 1'b0;
        wait_idle("ovf_idle", 600);
        check_val("ovf_pulses", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            check_val($sformatf("ovf_byte%0d", i), rx_q[i], 32'(8'h40 + i));
        end

        // missed handshake: uart never raises busy
        rx_q.delete();
        pulse_cyc.delete();
        uart_en = 1'b0;
        tick();
        write_seq(8'h11, 3);
        wait_idle("miss_idle", 100);
        check_val("miss_pulses", rx_q.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check_val("miss_gap01", pulse_cyc[1] - pulse_cyc[0], 6);
            check_val("miss_gap12", pulse_cyc[2] - pulse_cyc[1], 6);
            check_val("miss_byte2", rx_q[2], 8'h13);
        end

        // reset after the 2nd pulse of an 8-byte burst
        rx_q.delete();
        uart_en = 1'b1;
        busy_len = 5;
        tick();
        write_seq(8'h80, 8);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (rx_q.size() < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check_val("mid_two_pulses", rx_q.size(), 2);
        reset = 1'b0;
        #1;
        check_val("mid_rst_level", bus.level, 0);
        check_val("mid_rst_tx_wr", bus.tx_wr, 0);
        check_val("mid_rst_empty", bus.empty, 1);
        repeat (3) tick();
        reset = 1'b1;
        repeat (60) tick();
        @(negedge clk);
        check_val("mid_no_more", rx_q.size(), 2);
        check_val("mid_idle", bus.idle, 1);
        check_val("mid_level", bus.level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
